// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt pending/presentation front-end.
package intr_pkg;

  localparam int N_IRQ_DEF = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } intr_state_e;

endpackage

// File: rtl/intr_prio_enc.sv
// Highest-set-bit encoder: id is the index of the top set bit, 0 when none set.
module intr_prio_enc #(
  parameter int N    = 8,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  output logic [ID_W-1:0] id_o,
  output logic            any_o
);

  // Ascending scan so the highest set index is the last one written.
  always_comb begin
    id_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i]) id_o = ID_W'(i);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/intr_pending_ctrl.sv
// Interrupt front-end: rising-edge capture into sticky pending bits, masked priority
// presentation over valid/ready. Define IRQ_SYNC_EN to add a 2-flop input synchronizer.
module intr_pending_ctrl
  import intr_pkg::*;
#(
  parameter  int N_IRQ = N_IRQ_DEF,
  localparam int ID_W  = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] irq_en,
  output logic             vec_valid,
  output logic [ID_W-1:0]  vec_id,
  input  logic             vec_ready,
  output logic [N_IRQ-1:0] pending,
  output logic             lost
);

  intr_state_e      state_q, state_d;
  logic [N_IRQ-1:0] irq_in;
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] rise, clr;
  logic             vec_valid_q, vec_valid_d;
  logic [ID_W-1:0]  vec_id_q, vec_id_d;
  logic             lost_q, lost_d;
  logic             accept;
  logic [ID_W-1:0]  enc_id;
  logic             enc_any;

`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] irq_s1_q, irq_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_s1_q <= '0;
      irq_s2_q <= '0;
    end else begin
      irq_s1_q <= irq;
      irq_s2_q <= irq_s1_q;
    end
  end

  assign irq_in = irq_s2_q;
`else
  assign irq_in = irq;
`endif

  assign accept = vec_valid_q & vec_ready;
  assign rise   = irq_in & ~irq_q;

  always_comb begin
    clr = '0;
    if (accept) clr[vec_id_q] = 1'b1;
  end

  // A new rise on the bit being cleared keeps it pending and is not counted as lost.
  assign pending_d = (pending_q & ~clr) | rise;
  assign lost_d    = |(rise & pending_q & ~clr);

  intr_prio_enc #(
    .N    (N_IRQ),
    .ID_W (ID_W)
  ) u_prio_enc (
    .req_i (pending_q & irq_en),
    .id_o  (enc_id),
    .any_o (enc_any)
  );

  always_comb begin
    state_d     = state_q;
    vec_valid_d = vec_valid_q;
    vec_id_d    = vec_id_q;
    case (state_q)
      IDLE: begin
        if (enc_any) begin
          vec_id_d    = enc_id;
          vec_valid_d = 1'b1;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (accept) begin
          vec_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        vec_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      irq_q       <= '0;
      pending_q   <= '0;
      vec_valid_q <= 1'b0;
      vec_id_q    <= '0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq_in;
      pending_q   <= pending_d;
      vec_valid_q <= vec_valid_d;
      vec_id_q    <= vec_id_d;
      lost_q      <= lost_d;
    end
  end

  assign vec_valid = vec_valid_q;
  assign vec_id    = vec_id_q;
  assign pending   = pending_q;
  assign lost      = lost_q;

endmodule

// File: tb/tb_intr_pending_ctrl.sv
// Directed self-checking bench for intr_pending_ctrl (default build, no input synchronizer).
module tb_intr_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq;
  logic [7:0] irq_en;
  logic       vec_valid;
  logic [2:0] vec_id;
  logic       vec_ready;
  logic [7:0] pending;
  logic       lost;

  int n_chk  = 0;
  int n_fail = 0;

  intr_pending_ctrl #(.N_IRQ(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq       (irq),
    .irq_en    (irq_en),
    .vec_valid (vec_valid),
    .vec_id    (vec_id),
    .vec_ready (vec_ready),
    .pending   (pending),
    .lost      (lost)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; irq = '0; irq_en = '0; vec_ready = 1'b0;
    #1;
    chk("rst_valid",   vec_valid, 0);
    chk("rst_id",      vec_id,    0);
    chk("rst_pending", pending,   0);
    chk("rst_lost",    lost,      0);
    tick(2);
    rst_n = 1'b1;
    tick();

    // Single event: pending after edge 0, valid after edge 1
    irq_en = 8'hFF; irq = 8'h04;
    tick();
    chk("single_pend", pending,   8'h04);
    chk("single_lat",  vec_valid, 0);
    tick();
    chk("single_valid", vec_valid, 1);
    chk("single_id",    vec_id,    2);
    vec_ready = 1'b1;
    tick();
    chk("single_acc_pend",  pending,   8'h00);
    chk("single_acc_valid", vec_valid, 0);
    vec_ready = 1'b0; irq = '0;
    tick();

    // Priority: 7 first, then 0 after the mandatory idle cycle
    irq = 8'h81; vec_ready = 1'b1;
    tick();
    chk("prio_pend", pending, 8'h81);
    tick();
    chk("prio_valid7", vec_valid, 1);
    chk("prio_id7",    vec_id,    7);
    tick();
    chk("prio_acc7_pend",  pending,   8'h01);
    chk("prio_acc7_valid", vec_valid, 0);
    tick();
    chk("prio_ready_ignored", pending, 8'h01);
    chk("prio_valid0", vec_valid, 1);
    chk("prio_id0",    vec_id,    0);
    tick();
    chk("prio_acc0_pend", pending, 8'h00);
    vec_ready = 1'b0; irq = '0;
    tick();

    // Mask: masked pending retained, presented once enabled
    irq_en = 8'h01; irq = 8'h80;
    tick(3);
    chk("mask_pend",  pending,   8'h80);
    chk("mask_valid", vec_valid, 0);
    irq_en = 8'hFF;
    tick();
    chk("unmask_valid", vec_valid, 1);
    chk("unmask_id",    vec_id,    7);
    vec_ready = 1'b1;
    tick();
    chk("unmask_acc_pend", pending, 8'h00);
    vec_ready = 1'b0; irq = '0;
    tick();

    // Lost pulse on re-rise of a pending bit
    irq = 8'h08;
    tick(2);
    chk("lost_id", vec_id, 3);
    irq = '0;
    tick();
    irq = 8'h08;
    tick();
    chk("lost_pulse", lost,    1);
    chk("lost_pend",  pending, 8'h08);
    irq = '0;
    tick();
    chk("lost_not_sticky", lost, 0);
    // Re-rise on the accept edge of vec_id=3
    irq = 8'h08; vec_ready = 1'b1;
    tick();
    chk("same_edge_lost",  lost,      0);
    chk("same_edge_pend",  pending,   8'h08);
    chk("same_edge_valid", vec_valid, 0);
    vec_ready = 1'b0;
    tick();
    chk("same_edge_repres", vec_id, 3);
    chk("same_edge_rvalid", vec_valid, 1);
    vec_ready = 1'b1;
    tick();
    chk("same_edge_clear", pending, 8'h00);
    vec_ready = 1'b0; irq = '0;
    tick();

    // Stability: no pre-emption or retraction while presenting
    irq = 8'h02;
    tick(2);
    chk("stab_id1", vec_id, 1);
    irq = 8'h42; irq_en = 8'hFD;
    tick(2);
    chk("stab_pend",  pending,   8'h42);
    chk("stab_valid", vec_valid, 1);
    chk("stab_hold",  vec_id,    1);
    vec_ready = 1'b1;
    tick();
    chk("stab_acc_pend", pending, 8'h40);
    vec_ready = 1'b0;
    tick();
    chk("stab_next_id",    vec_id,    6);
    chk("stab_next_valid", vec_valid, 1);
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0; irq = '0; irq_en = 8'hFF;
    tick();
    chk("stab_final_pend", pending, 8'h00);

    // Reset mid-PRESENT with all bits pending
    irq = 8'hFF;
    tick(2);
    chk("prerst_pend",  pending,   8'hFF);
    chk("prerst_valid", vec_valid, 1);
    rst_n = 1'b0; irq = '0;
    #1;
    chk("midrst_valid", vec_valid, 0);
    chk("midrst_id",    vec_id,    0);
    chk("midrst_pend",  pending,   8'h00);
    chk("midrst_lost",  lost,      0);
    tick();
    rst_n = 1'b1;
    tick(3);
    chk("postrst_valid", vec_valid, 0);
    chk("postrst_pend",  pending,   8'h00);

    // Line held high across reset counts as one event after release
    rst_n = 1'b0; irq = 8'h01;
    tick();
    rst_n = 1'b1;
    tick();
    chk("held_pend",  pending, 8'h01);
    chk("held_lost",  lost,    0);
    tick();
    chk("held_valid", vec_valid, 1);
    chk("held_id",    vec_id,    0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
